crc32_stream: RTL

- Multi-byte-per-cycle streaming CRC-32 engine for the Ethernet datapath.
- Consumes a valid/ready byte stream of DATA_BYTES lanes, with a partial last beat.
- In GEN mode it produces the FCS of the frame. In CHECK mode the frame includes its received FCS, and the block flags good or bad.
- Sits beside the MAC TX/RX framers. Keeps per-mode frame statistics.

---
 rtl/crc32_pkg.sv | 50 +++++
 rtl/crc32_lane_fold.sv | 50 +++++
 rtl/crc32_stream.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/crc32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : crc32_pkg
//  Purpose  : Shared constants, FSM state encoding and the single-byte CRC-32
//             update used by the streaming CRC engine.
//  Contents : POLY_NORM / POLY_REFL     - generator polynomial, both bit orders
//             RESIDUE_NORM / RESIDUE_REFL - register value left after a frame
//                                          that already carries a valid FCS
//             CRC_INIT                   - register preset at frame start
//             state_t / ST_*             - engine state encoding
//             crc32_byte_upd()           - fold one byte into a CRC register
//  Revision : 1.0  initial release
// ============================================================================
package crc32_pkg;

    localparam logic [31:0] POLY_NORM    = 32'h04C11DB7;
    localparam logic [31:0] POLY_REFL    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE_NORM = 32'hC704DD7B;
    localparam logic [31:0] RESIDUE_REFL = 32'hDEBB20E3;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_BUSY   = 2'd1;
    localparam state_t ST_RESULT = 2'd2;

    // reflect=1: LSB-first, byte enters at crc[7:0], register shifts right.
    // reflect=0: MSB-first, byte enters at crc[31:24], register shifts left.
    function automatic logic [31:0] crc32_byte_upd(
        input logic [31:0] crc,
        input logic [7:0]  data,
        input logic        reflect
    );
        logic [31:0] c;
        if (reflect) begin
            c = crc ^ {24'h000000, data};
            for (int i = 0; i < 8; i++) begin
                c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
            end
        end else begin
            c = crc ^ {data, 24'h000000};
            for (int i = 0; i < 8; i++) begin
                c = c[31] ? ((c << 1) ^ POLY_NORM) : (c << 1);
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_lane_fold.sv
`default_nettype none
// ============================================================================
//  Module   : crc32_lane_fold
//  Purpose  : Combinational fold of up to DATA_BYTES byte lanes into a CRC
//             register, lane 0 first. lane_cnt selects how many lanes of the
//             chain contribute (1..DATA_BYTES).
//  Ports    : crc_in   [31:0]              - starting CRC register
//             data     [8*DATA_BYTES-1:0]  - lane k = data[8k+7:8k]
//             lane_cnt [KW-1:0]            - number of lanes to fold
//             crc_out  [31:0]              - register after the folded lanes
//  Revision : 1.0  initial release
// ============================================================================
module crc32_lane_fold
    import crc32_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter bit REFLECT    = 1'b1
) (
    input  logic [31:0]               crc_in,
    input  logic [8*DATA_BYTES-1:0]   data,
    input  logic [$clog2(DATA_BYTES+1)-1:0] lane_cnt,
    output logic [31:0]               crc_out
);

    localparam int KW = $clog2(DATA_BYTES + 1);

    // w_stage[k] is the register after lanes 0..k-1 have been folded.
    logic [31:0] w_stage [0:DATA_BYTES];

    assign w_stage[0] = crc_in;

    generate
        for (genvar k = 0; k < DATA_BYTES; k++) begin : g_lane
            assign w_stage[k+1] = crc32_byte_upd(w_stage[k], data[8*k +: 8], REFLECT);
        end
    endgenerate

    // Tap the chain after lane_cnt lanes; out-of-range counts fall back to a
    // full beat.
    always_comb begin
        crc_out = w_stage[DATA_BYTES];
        for (int k = 1; k <= DATA_BYTES; k++) begin
            if (lane_cnt == KW'(k)) begin
                crc_out = w_stage[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/crc32_stream.sv
`default_nettype none
// ============================================================================
//  Module   : crc32_stream
//  Purpose  : Streaming CRC-32 engine, DATA_BYTES lanes per beat. GEN mode
//             returns the frame FCS; CHECK mode (frame includes its FCS)
//             flags good/bad against the CRC residue and keeps saturating
//             good/bad frame counters.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             mode                - 0=GEN, 1=CHECK, latched on a frame's first beat
//             abort               - discard the frame in progress
//             s_valid/s_ready     - input beat handshake (s_ready registered)
//             s_data/s_keep/s_last- beat payload, lane enables, end of frame
//             res_valid/res_ready - result handshake
//             res_crc             - ~crc at end of frame
//             res_ok              - CHECK: residue match; GEN: 1
//             cnt_good/cnt_bad    - saturating CHECK-frame counters
//  Revision : 1.0  initial release
// ============================================================================
module crc32_stream
    import crc32_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter bit REFLECT    = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic                    abort,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_last,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [31:0]             res_crc,
    output logic                    res_ok,
    output logic [CNT_W-1:0]        cnt_good,
    output logic [CNT_W-1:0]        cnt_bad
);

    localparam int                KW        = $clog2(DATA_BYTES + 1);
    localparam logic [KW-1:0]     c_full    = KW'(DATA_BYTES);
    localparam logic [31:0]       c_residue = REFLECT ? RESIDUE_REFL : RESIDUE_NORM;
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_crc;
    logic               r_mode;
    logic               r_s_ready;
    logic               r_res_valid;
    logic [31:0]        r_res_crc;
    logic               r_res_ok;
    logic [CNT_W-1:0]   r_cnt_good;
    logic [CNT_W-1:0]   r_cnt_bad;

    logic               w_accept;
    logic               w_abort;
    logic               w_take_last;
    logic               w_frame_mode;
    logic [KW-1:0]      w_keep_pop;
    logic [KW-1:0]      w_lane_cnt;
    logic [31:0]        w_fold;
    logic               w_ok;

    // s_ready is low only in RESULT, so abort is naturally ignored there.
    assign w_accept    = s_valid && r_s_ready;
    assign w_abort     = abort && r_s_ready;
    assign w_take_last = w_accept && s_last && !abort;

    // The first beat of a frame uses the live mode input; later beats use the
    // copy latched on that first beat.
    assign w_frame_mode = (r_state == ST_IDLE) ? mode : r_mode;

    always_comb begin
        w_keep_pop = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            w_keep_pop = w_keep_pop + KW'(s_keep[k]);
        end
    end

    // Keep is honoured on the last beat only; an empty keep folds one lane.
    assign w_lane_cnt = !s_last             ? c_full :
                        (w_keep_pop == '0)  ? KW'(1) : w_keep_pop;

    crc32_lane_fold #(
        .DATA_BYTES (DATA_BYTES),
        .REFLECT    (REFLECT)
    ) u_fold (
        .crc_in   (r_crc),
        .data     (s_data),
        .lane_cnt (w_lane_cnt),
        .crc_out  (w_fold)
    );

    assign w_ok = w_frame_mode ? (w_fold == c_residue) : 1'b1;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_BUSY: begin
                if (w_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_accept) begin
                    w_state_next = s_last ? ST_RESULT : ST_BUSY;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc       <= CRC_INIT;
            r_mode      <= 1'b0;
            r_s_ready   <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_crc   <= 32'h0;
            r_res_ok    <= 1'b0;
            r_cnt_good  <= '0;
            r_cnt_bad   <= '0;
        end else begin
            // Handshake flags follow the next state so neither depends
            // combinationally on res_ready.
            r_s_ready   <= (w_state_next != ST_RESULT);
            r_res_valid <= (w_state_next == ST_RESULT);

            if (w_abort || w_take_last) begin
                r_crc <= CRC_INIT;
            end else if (w_accept) begin
                r_crc <= w_fold;
            end

            if (w_accept && !abort && (r_state == ST_IDLE)) begin
                r_mode <= mode;
            end

            if (w_take_last) begin
                r_res_crc <= ~w_fold;
                r_res_ok  <= w_ok;
                if (w_frame_mode) begin
                    if (w_ok) begin
                        if (r_cnt_good != c_cnt_max) begin
                            r_cnt_good <= r_cnt_good + CNT_W'(1);
                        end
                    end else begin
                        if (r_cnt_bad != c_cnt_max) begin
                            r_cnt_bad <= r_cnt_bad + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign s_ready   = r_s_ready;
    assign res_valid = r_res_valid;
    assign res_crc   = r_res_crc;
    assign res_ok    = r_res_ok;
    assign cnt_good  = r_cnt_good;
    assign cnt_bad   = r_cnt_bad;

endmodule
`default_nettype wire
